// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the imem request handshake and
// loads the IF/ID register, discarding wrong-path fetches across redirects.
//
// state | meaning
// FETCH | request at pc_q, deliver or redirect on ack
// HOLD  | fetched instruction parked in hold buffer while ID is stalled
// DROP  | wrong-path request at req_addr_q still outstanding; data dropped
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC        = 32'h0000_0000,
   parameter int unsigned INSTR_NUM_BYTES = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load_exceptn_vec_addr,
   input  logic [31:0] exception_vec_addr,
   input  logic        branch_redirect,
   input  logic [31:0] branch_target,
   input  logic        stall_IF,
   input  logic        exceptn_flush_ID_stg,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr_ID,
   output logic [31:0] cur_pc_plus_4_ID,
   output logic        instr_valid_ID
);

   typedef enum logic [1:0] {FETCH, HOLD, DROP} state_t;

   localparam logic [31:0] PC_INC = 32'(INSTR_NUM_BYTES);

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] req_addr_q, req_addr_d;
   logic [31:0] hold_instr_q, hold_instr_d;
   logic [31:0] hold_pc4_q, hold_pc4_d;
   logic [31:0] instr_id_q, instr_id_d;
   logic [31:0] pc4_id_q, pc4_id_d;
   logic        valid_id_q, valid_id_d;

   logic        redirect;
   logic [31:0] target;
   logic [31:0] pc_plus_4;
   logic        deliver;
   logic [31:0] dl_instr;
   logic [31:0] dl_pc4;

   always_comb begin
      redirect     = load_exceptn_vec_addr | branch_redirect;
      target       = load_exceptn_vec_addr ? exception_vec_addr : branch_target;
      target[1:0]  = 2'b00;
      pc_plus_4    = pc_q + PC_INC;

      state_d      = state_q;
      pc_d         = pc_q;
      req_addr_d   = req_addr_q;
      hold_instr_d = hold_instr_q;
      hold_pc4_d   = hold_pc4_q;
      instr_id_d   = instr_id_q;
      pc4_id_d     = pc4_id_q;
      valid_id_d   = valid_id_q;
      deliver      = 1'b0;
      dl_instr     = imem_rdata;
      dl_pc4       = pc_plus_4;

      unique case (state_q)
         FETCH: begin
            if (imem_ack) begin
               if (redirect) begin
                  pc_d = target;
               end else if (stall_IF) begin
                  hold_instr_d = imem_rdata;
                  hold_pc4_d   = pc_plus_4;
                  pc_d         = pc_plus_4;
                  state_d      = HOLD;
               end else begin
                  deliver = 1'b1;
                  pc_d    = pc_plus_4;
               end
            end else if (redirect) begin
               req_addr_d = pc_q;
               pc_d       = target;
               state_d    = DROP;
            end
         end
         HOLD: begin
            if (redirect) begin
               pc_d    = target;
               state_d = FETCH;
            end else if (!stall_IF) begin
               deliver  = 1'b1;
               dl_instr = hold_instr_q;
               dl_pc4   = hold_pc4_q;
               state_d  = FETCH;
            end
         end
         DROP: begin
            // A later redirect only retargets pc_q; the stale request still drains.
            if (redirect) pc_d = target;
            if (imem_ack) state_d = FETCH;
         end
         default: state_d = FETCH;
      endcase

      if (exceptn_flush_ID_stg) begin
         valid_id_d = 1'b0;
      end else if (!stall_IF) begin
         if (deliver) begin
            instr_id_d = dl_instr;
            pc4_id_d   = dl_pc4;
            valid_id_d = 1'b1;
         end else begin
            valid_id_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= FETCH;
         pc_q         <= RESET_PC;
         req_addr_q   <= RESET_PC;
         hold_instr_q <= '0;
         hold_pc4_q   <= '0;
         instr_id_q   <= '0;
         pc4_id_q     <= '0;
         valid_id_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         req_addr_q   <= req_addr_d;
         hold_instr_q <= hold_instr_d;
         hold_pc4_q   <= hold_pc4_d;
         instr_id_q   <= instr_id_d;
         pc4_id_q     <= pc4_id_d;
         valid_id_q   <= valid_id_d;
      end
   end

   assign imem_req         = rst_n & (state_q != HOLD);
   assign imem_addr        = (state_q == DROP) ? req_addr_q : pc_q;
   assign instr_ID         = instr_id_q;
   assign cur_pc_plus_4_ID = pc4_id_q;
   assign instr_valid_ID   = valid_id_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios pinned by literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_if_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        load_exceptn_vec_addr;
   logic [31:0] exception_vec_addr;
   logic        branch_redirect;
   logic [31:0] branch_target;
   logic        stall_IF;
   logic        exceptn_flush_ID_stg;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr_ID;
   logic [31:0] cur_pc_plus_4_ID;
   logic        instr_valid_ID;

   int errors = 0;
   int checks = 0;

   localparam logic [31:0] PAT = 32'hA5A5_A5A5;

   if_fetch_unit #(.RESET_PC(32'h0), .INSTR_NUM_BYTES(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .load_exceptn_vec_addr(load_exceptn_vec_addr),
      .exception_vec_addr(exception_vec_addr),
      .branch_redirect(branch_redirect), .branch_target(branch_target),
      .stall_IF(stall_IF), .exceptn_flush_ID_stg(exceptn_flush_ID_stg),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instr_ID(instr_ID), .cur_pc_plus_4_ID(cur_pc_plus_4_ID),
      .instr_valid_ID(instr_valid_ID)
   );

   always #5 clk = ~clk;

   // Behavioural model: next fetch address, an optional wrong-path request
   // that must drain, an optional parked instruction, and the IF/ID contents.
   logic [31:0] m_pc;
   bit          m_stale;
   logic [31:0] m_stale_addr;
   bit          m_parked;
   logic [31:0] m_park_instr, m_park_pc4;
   logic [31:0] m_instr, m_pc4;
   bit          m_valid;

   function automatic logic [31:0] m_addr();
      return m_stale ? m_stale_addr : m_pc;
   endfunction

   task automatic m_reset();
      m_pc = 32'h0; m_stale = 0; m_stale_addr = 32'h0; m_parked = 0;
      m_park_instr = 32'h0; m_park_pc4 = 32'h0;
      m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 0;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      chk("model imem_req", {31'b0, imem_req}, {31'b0, !m_parked});
      chk("model imem_addr", imem_addr, m_addr());
      chk("model instr_ID", instr_ID, m_instr);
      chk("model pc_plus_4_ID", cur_pc_plus_4_ID, m_pc4);
      chk("model instr_valid_ID", {31'b0, instr_valid_ID}, {31'b0, m_valid});
   endtask

   // Drive one cycle's inputs at the falling edge, advance the model across
   // the rising edge, then compare at the next falling edge.
   task automatic cycle(input bit a, input bit st, input bit br, input logic [31:0] bt,
                        input bit ex, input logic [31:0] ev, input bit fl);
      bit          redir, got;
      logic [31:0] tgt, rdata, gi, gp;
      rdata = m_addr() ^ PAT;
      imem_ack = a; imem_rdata = rdata; stall_IF = st;
      branch_redirect = br; branch_target = bt;
      load_exceptn_vec_addr = ex; exception_vec_addr = ev;
      exceptn_flush_ID_stg = fl;

      redir = ex | br;
      tgt   = (ex ? ev : bt) & 32'hFFFF_FFFC;
      got = 0; gi = 32'h0; gp = 32'h0;
      if (m_parked) begin
         if (redir) begin m_parked = 0; m_pc = tgt; end
         else if (!st) begin got = 1; gi = m_park_instr; gp = m_park_pc4; m_parked = 0; end
      end else if (m_stale) begin
         if (redir) m_pc = tgt;
         if (a) m_stale = 0;
      end else if (a) begin
         if (redir) m_pc = tgt;
         else if (st) begin
            m_parked = 1; m_park_instr = rdata; m_park_pc4 = m_pc + 4; m_pc = m_pc + 4;
         end else begin
            got = 1; gi = rdata; gp = m_pc + 4; m_pc = m_pc + 4;
         end
      end else if (redir) begin
         m_stale = 1; m_stale_addr = m_pc; m_pc = tgt;
      end
      if (fl) m_valid = 0;
      else if (!st) begin
         if (got) begin m_instr = gi; m_pc4 = gp; m_valid = 1; end
         else m_valid = 0;
      end

      @(negedge clk);
      check_model();
   endtask

   task automatic simple(input bit a, input bit st);
      cycle(a, st, 0, 32'h0, 0, 32'h0, 0);
   endtask

   task automatic reset_pulse();
      rst_n = 1'b0;
      #1;
      chk("rst imem_req", {31'b0, imem_req}, 32'h0);
      chk("rst instr_ID", instr_ID, 32'h0);
      chk("rst pc_plus_4_ID", cur_pc_plus_4_ID, 32'h0);
      chk("rst instr_valid_ID", {31'b0, instr_valid_ID}, 32'h0);
      m_reset();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_model();
      chk("post-rst imem_addr", imem_addr, 32'h0);
      chk("post-rst imem_req", {31'b0, imem_req}, 32'h1);
   endtask

   initial begin
      rst_n = 1'b0; imem_ack = 0; imem_rdata = 0; stall_IF = 0;
      branch_redirect = 0; branch_target = 0;
      load_exceptn_vec_addr = 0; exception_vec_addr = 0; exceptn_flush_ID_stg = 0;
      m_reset();
      @(negedge clk);
      @(negedge clk);
      reset_pulse();

      // Back-to-back fetch
      simple(1, 0);
      chk("b2b addr 4", imem_addr, 32'h4);
      chk("b2b pc4 4", cur_pc_plus_4_ID, 32'h4);
      chk("b2b instr 0", instr_ID, 32'hA5A5_A5A5);
      chk("b2b valid", {31'b0, instr_valid_ID}, 32'h1);
      simple(1, 0);
      chk("b2b addr 8", imem_addr, 32'h8);
      chk("b2b pc4 8", cur_pc_plus_4_ID, 32'h8);

      // Stall while ack at 0x8
      simple(1, 1);
      chk("hold req", {31'b0, imem_req}, 32'h0);
      chk("hold pc4 unchanged", cur_pc_plus_4_ID, 32'h8);
      simple(1, 1);
      simple(1, 1);
      chk("hold still req0", {31'b0, imem_req}, 32'h0);
      simple(0, 0);
      chk("release instr", instr_ID, 32'h8 ^ PAT);
      chk("release pc4", cur_pc_plus_4_ID, 32'hC);
      chk("release addr", imem_addr, 32'hC);

      // Redirect with no ack -> stale request drains
      simple(1, 0);
      chk("pre-drop addr", imem_addr, 32'h10);
      cycle(0, 0, 1, 32'h103, 0, 32'h0, 0);
      chk("drop addr", imem_addr, 32'h10);
      simple(0, 0);
      chk("drop addr still", imem_addr, 32'h10);
      simple(1, 0);
      chk("drop done addr", imem_addr, 32'h100);
      chk("drop data discarded", {31'b0, instr_valid_ID}, 32'h0);

      // Exception beats branch
      cycle(1, 0, 1, 32'h200, 1, 32'h8000_0180, 0);
      chk("exc prio addr", imem_addr, 32'h8000_0180);

      // Flush over stall
      simple(1, 0);
      chk("pre-flush valid", {31'b0, instr_valid_ID}, 32'h1);
      chk("pre-flush pc4", cur_pc_plus_4_ID, 32'h8000_0184);
      cycle(0, 1, 0, 32'h0, 0, 32'h0, 1);
      chk("flush valid", {31'b0, instr_valid_ID}, 32'h0);

      // PC wrap, then reset in the middle of a drop
      cycle(1, 0, 1, 32'hFFFF_FFFC, 0, 32'h0, 0);
      chk("wrap addr", imem_addr, 32'hFFFF_FFFC);
      simple(1, 0);
      chk("wrap pc4", cur_pc_plus_4_ID, 32'h0);
      chk("wrap next addr", imem_addr, 32'h0);
      simple(1, 0);
      cycle(0, 0, 1, 32'h40, 0, 32'h0, 0);
      chk("mid-drop addr", imem_addr, 32'h4);
      reset_pulse();

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         if (i % 300 == 299) reset_pulse();
         else cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 9) == 0, $urandom,
                    $urandom_range(0, 19) == 0, $urandom,
                    $urandom_range(0, 15) == 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
